// File: rtl/mac_pkg.sv
// Shared constants and the operand tuple type for the MAC issue controller.
// Purely declarative; no latency or flow control of its own.
package mac_pkg;
    localparam int LAT_DEF   = 6;
    localparam int OP_W_DEF  = 32;
    localparam int RES_W_DEF = 64;
    localparam int TAG_W     = 4;

    typedef struct packed {
        logic [OP_W_DEF-1:0] a;
        logic [OP_W_DEF-1:0] b;
        logic [OP_W_DEF-1:0] c;
        logic [OP_W_DEF-1:0] d;
        logic [OP_W_DEF-1:0] e;
    } tuple_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, non-fall-through: a push is visible at the head one cycle later.
// No internal backpressure; the caller never pushes when full nor pops when empty.
module sync_fifo #(
    parameter int W     = 68,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 push_dat,
    input  logic                         pop,
    output logic [W-1:0]                 pop_dat,
    output logic                         not_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign not_empty = (count != '0);
    // Storage is not reset, so the head reads as zero whenever nothing is buffered.
    assign pop_dat   = not_empty ? mem[rd_ptr] : '0;
endmodule

// File: rtl/mac_issue_ctrl.sv
// Credit-based issue of operand tuples into a fixed-latency MAC pipeline, results buffered with tags.
// Issue-to-out_valid is LAT+2 cycles; in_ready drops when every FIFO slot is reserved.
module mac_issue_ctrl
    import mac_pkg::*;
#(
    parameter int LAT       = LAT_DEF,
    parameter int RES_DEPTH = 4,
    parameter int OP_W      = OP_W_DEF,
    parameter int RES_W     = RES_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [OP_W-1:0]  in_c,
    input  logic [OP_W-1:0]  in_d,
    input  logic [OP_W-1:0]  in_e,
    output logic [OP_W-1:0]  op_a,
    output logic [OP_W-1:0]  op_b,
    output logic [OP_W-1:0]  op_c,
    output logic [OP_W-1:0]  op_d,
    output logic [OP_W-1:0]  op_e,
    output logic             op_fire,
    input  logic [RES_W-1:0] pipe_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] out_data,
    output logic [3:0]       out_tag,
    output logic             busy
);
    localparam int CW = $clog2(RES_DEPTH + 1);

    logic                   rdy_en;
    logic [CW-1:0]          credits;
    logic                   issue;
    logic                   pop;
    tuple_t                 op_q;
    logic [TAG_W-1:0]       tag_cnt;
    logic [TAG_W-1:0]       op_tag;
    logic [LAT-1:0]         vsr;
    logic [TAG_W-1:0]       tag_sr [LAT];
    logic [CW-1:0]          fifo_count;
    logic [RES_W+TAG_W-1:0] head;

    // Credits reserve a FIFO slot at issue time, so a capture can never find the FIFO full.
    assign in_ready = rdy_en && (credits != '0);
    assign issue    = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdy_en  <= 1'b0;
            credits <= CW'(RES_DEPTH);
            op_q    <= '0;
            op_fire <= 1'b0;
            op_tag  <= '0;
            tag_cnt <= '0;
            vsr     <= '0;
            for (int k = 0; k < LAT; k++) begin
                tag_sr[k] <= '0;
            end
        end else begin
            rdy_en  <= 1'b1;
            credits <= credits - CW'(issue) + CW'(pop);
            op_fire <= issue;
            if (issue) begin
                op_q    <= '{a: in_a, b: in_b, c: in_c, d: in_d, e: in_e};
                op_tag  <= tag_cnt;
                tag_cnt <= tag_cnt + TAG_W'(1);
            end
            // Tags ride alongside the valid bits so each capture carries its issue number.
            vsr[0]    <= op_fire;
            tag_sr[0] <= op_tag;
            for (int k = 1; k < LAT; k++) begin
                vsr[k]    <= vsr[k-1];
                tag_sr[k] <= tag_sr[k-1];
            end
        end
    end

    assign op_a = op_q.a;
    assign op_b = op_q.b;
    assign op_c = op_q.c;
    assign op_d = op_q.d;
    assign op_e = op_q.e;

    sync_fifo #(
        .W     (RES_W + TAG_W),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vsr[LAT-1]),
        .push_dat  ({tag_sr[LAT-1], pipe_y}),
        .pop       (pop),
        .pop_dat   (head),
        .not_empty (out_valid),
        .count     (fifo_count)
    );

    assign out_data = head[RES_W-1:0];
    assign out_tag  = head[RES_W +: TAG_W];
    assign busy     = op_fire || (vsr != '0) || (fifo_count != '0);
endmodule

// File: doc/mac_issue_ctrl.md
MAC_ISSUE_CTRL -- requirements
Module: mac_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT, default 6: cycles from op_fire high to pipe_y carrying that tuple's result.
REQ-002 SHALL have parameter RES_DEPTH, default 4: result FIFO entries; power of two, at most 16.
REQ-003 SHALL have parameter OP_W, default 32: operand width.
REQ-004 SHALL have parameter RES_W, default 64: result width.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic rises on posedge.
REQ-006 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have ports in_valid input 1 and in_ready output 1: operand-tuple handshake.
REQ-008 SHALL have ports in_a, in_b, in_c, in_d, in_e, input, OP_W each: the operand tuple.
REQ-009 SHALL have ports op_a, op_b, op_c, op_d, op_e, output, OP_W each: operands driven to the arithmetic pipeline.
REQ-010 SHALL have port op_fire, output, 1: marks the cycle a new tuple is presented on op_*.
REQ-011 SHALL have port pipe_y, input, RES_W: result returned by the pipeline.
REQ-012 SHALL have ports out_valid output 1 and out_ready input 1: result handshake.
REQ-013 SHALL have port out_data, output, RES_W: head result.
REQ-014 SHALL have port out_tag, output, 4: issue sequence number of the head result.
REQ-015 SHALL have port busy, output, 1: high while any tuple is in flight or buffered.

Function
REQ-016 SHALL issue a tuple in any cycle where in_valid && in_ready.
REQ-017 SHALL drive in_ready = (credits != 0); credits is a register, so in_ready has no combinational path from in_valid or out_ready.
REQ-018 SHALL maintain credits = RES_DEPTH - inflight - fifo_count:
  - issue decrements credits; pop increments it; both in one cycle leaves it unchanged.
  - credits SHALL never underflow or exceed RES_DEPTH.
REQ-019 SHALL register in_a..in_e into op_a..op_e on the issue edge, with op_fire high for exactly the following cycle.
REQ-020 SHALL hold op_a..op_e at the last issued tuple while no issue occurs.
REQ-021 SHALL track in flight with an LAT-deep valid shift register fed by op_fire; pipe_y SHALL be captured exactly LAT cycles after op_fire, with no other sampling of pipe_y.
REQ-022 SHALL push the captured result and its tag into the result FIFO; credits guarantee no push when full.
REQ-023 SHALL assign tags from a 4-bit counter incremented per issue, wrapping 15->0.
REQ-024 SHALL drive out_valid = FIFO non-empty, with out_data/out_tag at the head; pop on out_valid && out_ready.
REQ-025 SHALL be non-fall-through: a push into an empty FIFO sets out_valid on the next cycle.
REQ-026 SHALL keep count unchanged on simultaneous push and pop; pointers wrap modulo RES_DEPTH.
REQ-027 SHALL hold out_data/out_tag stable while out_valid && !out_ready.
REQ-028 SHALL drive busy = (inflight != 0) || (fifo_count != 0).

Reset
REQ-029 SHALL, while rst_n is low at a clock edge, set: in_ready=0, op_*=0, op_fire=0, out_valid=0, out_data=0, out_tag=0, busy=0, valid shift register clear, tag=0, FIFO empty, credits=RES_DEPTH.
REQ-030 SHALL raise in_ready in the first cycle after rst_n is sampled high.
REQ-031 SHALL, on reset mid-operation, discard all in-flight and buffered results with no later capture or output.

Structure
REQ-032 SHALL take LAT default, OP_W, RES_W and a packed tuple struct typedef from shared package mac_pkg.
REQ-033 SHALL implement the result FIFO as sub-module sync_fifo, parameterised by width and depth.

Verification
REQ-034 SHALL cover single issue: tuple (2,3,4,5,7) issued at t -> op_fire at t+1; pipe_y=0x1234 at t+7 captured; out_valid at t+8 with out_data=0x1234, out_tag=0.
REQ-035 SHALL cover backpressure: out_ready=0, in_valid held -> exactly 4 issues, then in_ready=0; after one pop, in_ready=1 the next cycle and a 5th tuple issues.
REQ-036 SHALL cover simultaneous issue and pop at credits=1 -> credits stays 1 and in_ready stays high.
REQ-037 SHALL cover tag wrap: 17 tuples streamed with out_ready=1 -> tags 0..15, then 0, in order with no loss.
REQ-038 SHALL cover mid-flight reset: rst_n low for 1 cycle with 2 in flight and 1 buffered -> no out_valid afterwards, credits=4, busy=0.
